// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the enable-gated serial capture chain.
// Holds the transmitter state encoding, the default word width and bit
// period (shared with the matching serial-capture register), and a helper
// that sizes the down-counters.
package seq_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_DIV   = 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } tx_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_period_ctr.sv
// bit_period_ctr: down-counter with synchronous reset, parallel load and a
// terminal-count flag. Used both as the bit-period divider and as the
// bit counter of piso_tx.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val (takes priority over dec)
//   load_val  value loaded on load
//   dec       decrement by one; holds at zero
//   count     current count
//   at_zero   count == 0
module bit_period_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_zero
);

  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !at_zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per DIV-cycle bit period,
// with a one-cycle capture strobe at the start of every bit period.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word in flight; sout/sen low, ready for a word
// SHIFT | transmitting; ready only in the final cycle of the word
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         parallel word, captured on an accepted load
//   load_valid  din is valid
//   load_ready  block can accept a word this cycle (combinational)
//   sout        serial data, registered
//   sen         capture strobe, first cycle of each bit period, registered
//   busy        a word is being transmitted, registered
//   done        final cycle of the last bit period, registered
module piso_tx
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH,
  parameter int DIV       = SEQ_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sen,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = ctr_width(WIDTH);
  localparam int DIV_W = ctr_width(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             bit_zero;
  logic             div_zero;

  logic in_shift;
  logic word_end;
  logic accept;
  logic step;
  logic din_head;
  logic head_next;
  logic done_d;

  logic sout_q;
  logic sen_q;
  logic busy_q;
  logic done_q;

  assign in_shift   = (state == S_SHIFT);
  assign word_end   = in_shift && bit_zero && div_zero;
  assign load_ready = !in_shift || word_end;
  assign accept     = load_valid && load_ready;
  // Move to the next bit of the current word (not on the last bit).
  assign step       = in_shift && div_zero && !bit_zero;

  // Divider restarts on every new bit period, including the first one.
  bit_period_ctr #(.W(DIV_W)) u_div_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || step),
    .load_val (DIV_LAST),
    .dec      (in_shift),
    .count    (div_cnt),
    .at_zero  (div_zero)
  );

  bit_period_ctr #(.W(BIT_W)) u_bit_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (BIT_LAST),
    .dec      (step),
    .count    (bit_cnt),
    .at_zero  (bit_zero)
  );

  always_comb begin
    din_head  = 1'b0;
    head_next = 1'b0;
    if (MSB_FIRST) begin
      din_head  = din[WIDTH-1];
      head_next = shreg[WIDTH-2];
    end else begin
      din_head  = din[0];
      head_next = shreg[1];
    end
  end

  // done is registered, so predict whether the next cycle is the final
  // cycle of the word: both counters will be zero and no new word started.
  always_comb begin
    done_d = 1'b0;
    if (in_shift && !word_end) begin
      if (step) begin
        done_d = (bit_cnt == BIT_W'(1)) && (DIV == 1);
      end else begin
        done_d = bit_zero && (div_cnt == DIV_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      sout_q <= 1'b0;
      sen_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sen_q  <= accept || step;
      done_q <= done_d;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_SHIFT;
            shreg  <= din;
            sout_q <= din_head;
            busy_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            // back-to-back word: stay in SHIFT with no gap
            shreg  <= din;
            sout_q <= din_head;
          end else if (word_end) begin
            state  <= S_IDLE;
            sout_q <= 1'b0;
            busy_q <= 1'b0;
          end else if (step) begin
            shreg  <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            sout_q <= head_next;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sout = sout_q;
  assign sen  = sen_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx using three instances:
//   dut_a: WIDTH=8 DIV=1 MSB first
//   dut_b: WIDTH=8 DIV=3 LSB first
//   dut_c: WIDTH=8 DIV=2 MSB first
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic       rst_a, lv_a, lr_a, sout_a, sen_a, busy_a, done_a;
  logic [7:0] din_a;
  logic       rst_b, lv_b, lr_b, sout_b, sen_b, busy_b, done_b;
  logic [7:0] din_b;
  logic       rst_c, lv_c, lr_c, sout_c, sen_c, busy_c, done_c;
  logic [7:0] din_c;

  piso_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .load_valid(lv_a),
    .load_ready(lr_a), .sout(sout_a), .sen(sen_a), .busy(busy_a), .done(done_a)
  );

  piso_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .load_valid(lv_b),
    .load_ready(lr_b), .sout(sout_b), .sen(sen_b), .busy(busy_b), .done(done_b)
  );

  piso_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .din(din_c), .load_valid(lv_c),
    .load_ready(lr_c), .sout(sout_c), .sen(sen_c), .busy(busy_c), .done(done_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    din_a = 8'h00; din_b = 8'h00; din_c = 8'h00;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if ({lr_a, sout_a, sen_a, busy_a, done_a} !== 5'b10000)
        $display("FAIL reset_idle_a cycle %0d: got %b expected 10000", i,
                 {lr_a, sout_a, sen_a, busy_a, done_a});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({lr_b, sout_b, sen_b, busy_b, done_b} !== 5'b10000)
      $display("FAIL reset_idle_b: got %b expected 10000",
               {lr_b, sout_b, sen_b, busy_b, done_b});
    else pass_cnt++;
    total_cnt++;
    if ({lr_c, sout_c, sen_c, busy_c, done_c} !== 5'b10000)
      $display("FAIL reset_idle_c: got %b expected 10000",
               {lr_c, sout_c, sen_c, busy_c, done_c});
    else pass_cnt++;
  endtask

  // Loads w on dut_a and checks the 8 DIV=1 MSB-first bit cycles.
  task automatic send_a(input logic [7:0] w, input string name);
    logic [3:0] exp;
    din_a = w;
    lv_a  = 1'b1;
    tick();
    lv_a  = 1'b0;
    din_a = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp = {w[7-i], 1'b1, 1'b1, (i == 7)};
      total_cnt++;
      if ({sout_a, sen_a, busy_a, done_a} !== exp)
        $display("FAIL %s bit %0d: got sout/sen/busy/done=%b expected %b", name, i,
                 {sout_a, sen_a, busy_a, done_a}, exp);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({lr_a, sout_a, sen_a, busy_a, done_a} !== 5'b10000)
      $display("FAIL %s after: got %b expected 10000", name,
               {lr_a, sout_a, sen_a, busy_a, done_a});
    else pass_cnt++;
  endtask

  task automatic test_msb_div1();
    send_a(8'hA5, "msb_div1");
  endtask

  task automatic test_lsb_div3();
    logic [7:0] w;
    logic [3:0] exp;
    int nsen;
    w = 8'h81;
    nsen = 0;
    din_b = w;
    lv_b  = 1'b1;
    tick();
    lv_b  = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (sen_b) nsen++;
      exp = {w[c/3], (c % 3 == 0), 1'b1, (c == 23)};
      total_cnt++;
      if ({sout_b, sen_b, busy_b, done_b} !== exp)
        $display("FAIL lsb_div3 cycle %0d: got sout/sen/busy/done=%b expected %b", c,
                 {sout_b, sen_b, busy_b, done_b}, exp);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (nsen !== 8)
      $display("FAIL lsb_div3 sen_count: got %0d expected 8", nsen);
    else pass_cnt++;
    total_cnt++;
    if ({sen_b, busy_b} !== 2'b00)
      $display("FAIL lsb_div3 after: got sen/busy=%b expected 00", {sen_b, busy_b});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic [4:0] exp;
    logic d;
    int k;
    din_c = 8'hF0;
    lv_c  = 1'b1;
    tick();
    din_c = 8'h0F;
    for (int c = 0; c < 32; c++) begin
      if (c == 16) lv_c = 1'b0;
      w = (c < 16) ? 8'hF0 : 8'h0F;
      k = (c % 16) / 2;
      d = (c == 15) || (c == 31);
      exp = {w[7-k], (c % 2 == 0), 1'b1, d, d};
      total_cnt++;
      if ({sout_c, sen_c, busy_c, done_c, lr_c} !== exp)
        $display("FAIL back_to_back cycle %0d: got sout/sen/busy/done/ready=%b expected %b",
                 c, {sout_c, sen_c, busy_c, done_c, lr_c}, exp);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({sout_c, sen_c, busy_c, done_c} !== 4'b0000)
      $display("FAIL back_to_back after: got %b expected 0000",
               {sout_c, sen_c, busy_c, done_c});
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    din_a = 8'hFF;
    lv_a  = 1'b1;
    tick();
    lv_a  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({sout_a, sen_a, busy_a, done_a} !== 4'b1110)
        $display("FAIL midframe bit %0d: got %b expected 1110", i,
                 {sout_a, sen_a, busy_a, done_a});
      else pass_cnt++;
      tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    total_cnt++;
    if ({lr_a, sout_a, sen_a, busy_a, done_a} !== 5'b10000)
      $display("FAIL midframe reset: got %b expected 10000",
               {lr_a, sout_a, sen_a, busy_a, done_a});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({sen_a, busy_a, done_a} !== 3'b000)
        $display("FAIL midframe quiet cycle %0d: got %b expected 000", i,
                 {sen_a, busy_a, done_a});
      else pass_cnt++;
    end
    send_a(8'h3C, "after_reset");
    // reset wins over a simultaneous load
    rst_a = 1'b1;
    lv_a  = 1'b1;
    din_a = 8'hFF;
    tick();
    rst_a = 1'b0;
    lv_a  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({sout_a, sen_a, busy_a} !== 3'b000)
        $display("FAIL reset_priority cycle %0d: got %b expected 000", i,
                 {sout_a, sen_a, busy_a});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_ignored_input();
    logic [7:0] w;
    logic [3:0] exp;
    int nsen;
    w = 8'h6B;
    nsen = 0;
    din_b = w;
    lv_b  = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      lv_b  = (c < 23) ? (c % 2 == 1) : 1'b0;
      din_b = 8'(c * 37 + 5);
      if (sen_b) nsen++;
      exp = {w[c/3], (c % 3 == 0), 1'b1, (c == 23)};
      total_cnt++;
      if ({sout_b, sen_b, busy_b, done_b} !== exp)
        $display("FAIL ignored_input cycle %0d: got sout/sen/busy/done=%b expected %b", c,
                 {sout_b, sen_b, busy_b, done_b}, exp);
      else pass_cnt++;
      tick();
    end
    lv_b = 1'b0;
    total_cnt++;
    if (nsen !== 8)
      $display("FAIL ignored_input sen_count: got %0d expected 8", nsen);
    else pass_cnt++;
    total_cnt++;
    if ({sen_b, busy_b} !== 2'b00)
      $display("FAIL ignored_input after: got sen/busy=%b expected 00", {sen_b, busy_b});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_div1();
    test_lsb_div3();
    test_back_to_back();
    test_reset_midframe();
    test_ignored_input();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d",
             pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that drives a serial data bit plus a one-cycle capture-enable strobe, the sending end of the enable-gated flip-flop capture chain in the sequential circuits library. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per DIV-cycle bit period. Downstream enable-gated registers sample `sout` whenever `sen` is high. Supports back-to-back words with no idle gap.

## Interface
- `WIDTH`, 8: word width in bits, at least 2.
- `DIV`, 1: clock cycles per bit period, at least 1.
- `MSB_FIRST`, 1: 1 means bit WIDTH-1 is sent first; 0 means bit 0 is sent first.

- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word, sampled on an accepted load.
- `load_valid`  in  1  `din` is valid.
- `load_ready`  out  1  the block can accept a word this cycle.
- `sout`  out  1  serial data, registered.
- `sen`  out  1  capture strobe, registered; high for exactly the first cycle of each bit period.
- `busy`  out  1  high while a word is being transmitted.
- `done`  out  1  one-cycle pulse in the final cycle of the last bit period.

## Operation
- **States:** IDLE and SHIFT.
- **Accept:** a word is accepted when `load_valid && load_ready` at a rising edge.
  - On acceptance, the shift register loads `din`.
  - The bit counter loads WIDTH-1 and the divider loads DIV-1.
  - The FSM enters SHIFT.
- **load_ready:** combinational.
  - High in IDLE.
  - High in SHIFT only when bit count is 0 and divider is 0, i.e. the same cycle as `done`.
- **SHIFT, each cycle:**
  - If the divider is nonzero, decrement it.
  - Otherwise reload the divider with DIV-1 and shift to the next bit.
  - When bit count is 0 and divider is 0, the word is finished. The FSM goes to IDLE, or stays in SHIFT with the new word if a load is accepted in that cycle.
- **sout:** the current head bit, MSB or LSB per `MSB_FIRST`. It is stable for the whole bit period.
- **sen:** high on the first cycle of each bit period, so exactly WIDTH pulses per word, DIV cycles apart.
- **busy:** high in SHIFT.
- **In IDLE:** `sout`=0, `sen`=0.
- **Input changes:** `load_valid` or `din` changes while `load_ready`=0 are ignored.
- **Counter widths:**
  - Bit counter is $clog2(WIDTH) bits.
  - Divider is max(1,$clog2(DIV)) bits.
  - With DIV=1 the divider is constant 0 and `sen` is high every SHIFT cycle.

## Timing
- **Reset values:** `sout`=0, `sen`=0, `busy`=0, `done`=0. State is IDLE, so `load_ready`=1 in the first cycle after reset.
- **Latency:** load accepted at edge N, then first bit on `sout` with `sen`=1 in cycle N+1.
- **Frame length:** WIDTH×DIV cycles from the first `sen` to the end of the `done` cycle.
- **Back-to-back:** a load accepted in the `done` cycle puts the new first bit out in the next cycle. There is no gap, and the `sen` spacing stays exactly DIV.
- **Reset mid-frame:** the frame is aborted. The next cycle shows reset values, with no `done` and no further `sen`. The partial word is discarded.
- **Reset priority:** `rst` and an accepted load in the same cycle resolve to reset; the word is dropped.

## Structure
- Shared package `seq_pkg` holds:
  - the state encoding localparams (`ST_IDLE`, `ST_SHIFT`);
  - the default WIDTH/DIV constants, shared with the matching serial-capture register.
- Natural sub-module: `bit_period_ctr`.
  - Down-counter with synchronous reset, load, and `at_zero`.
  - Instantiated once for the divider; the bit counter reuses the same module.
- The top holds the FSM, shift register, and output registers.

## Test plan
- **Reset and idle:** WIDTH=8, DIV=1. Hold `rst` 3 cycles, then release with `load_valid`=0 → `load_ready`=1, `sout`=0, `sen`=0, `busy`=0 for 10 cycles.
- **MSB-first, DIV=1:** load 8'hA5 → `sout` sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, `sen`=1 all 8. `done` is high with the 8th bit; `busy` falls next cycle.
- **LSB-first, DIV=3:** MSB_FIRST=0, load 8'h81 → bits 1,0,0,0,0,0,0,1, each held 3 cycles. Exactly 8 `sen` pulses, 3 cycles apart; frame is 24 cycles.
- **Back-to-back:** DIV=2. Load 8'hF0, then hold `load_valid` with 8'h0F → second word accepted in the `done` cycle. 16 bits go out continuously, the `sen` spacing is 2 throughout, and there are two `done` pulses 16 cycles apart.
- **Reset mid-frame:** load 8'hFF, assert `rst` after 4 bits → next cycle `sout`=0, `sen`=0, `busy`=0, no `done`. A fresh 8'h3C load then transmits correctly.
- **Ignored input:** toggle `load_valid`/`din` during SHIFT → the transmitted bits match the originally accepted word, with no extra `sen` pulses.
